// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter that shares one ALU between two requesters.
// It accepts one request, issues it with a start pulse, and waits for done
// under a timeout guard. It then returns the result to the winning requester.
module alu_req_arbiter #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned OP_W    = 3,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_err,
  output logic              alu_start,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic              grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                err_q, err_d;
  logic                grant_q, grant_d;
  logic                last_q, last_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                win;
  logic                rsp_hs;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Winner selection, next-state logic and datapath updates
  always_comb begin
    // When both requesters are valid, the one not granted last time wins.
    // With a single valid requester, that requester wins.
    if (req0_valid && req1_valid) win = ~last_q;
    else                          win = req1_valid;
    rsp_hs  = (state_q == S_RESP) && (grant_q ? rsp1_ready : rsp0_ready);

    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_d = win;
          op_d    = win ? req1_op : req0_op;
          a_d     = win ? req1_a  : req0_a;
          b_d     = win ? req1_b  : req0_b;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (alu_done) begin
          res_d   = alu_result;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        if (rsp_hs) begin
          last_d  = grant_q;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status outputs. Ready is masked during reset because
  // the synchronous reset would discard the accept.
  always_comb begin
    req0_ready = ~rst && (state_q == S_IDLE) && req0_valid && ~win;
    req1_ready = ~rst && (state_q == S_IDLE) && req1_valid &&  win;
    rsp0_valid = (state_q == S_RESP) && ~grant_q;
    rsp1_valid = (state_q == S_RESP) &&  grant_q;
    alu_start  = (state_q == S_ISSUE);
    busy       = (state_q != S_IDLE);
    alu_op     = op_q;
    alu_a      = a_q;
    alu_b      = b_q;
    rsp_result = res_q;
    rsp_err    = err_q;
    grant_id   = grant_q;
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed self-checking bench for alu_req_arbiter with a latency-programmable ALU model.
module tb_alu_req_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [7:0] rsp_result;
  logic       rsp_err;
  logic       alu_start;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b;
  logic       alu_done;
  logic [7:0] alu_result;
  logic       busy;
  logic       grant_id;

  int n_checks = 0;
  int n_fail   = 0;

  // ALU model: answers alu_lat cycles after the start pulse. A latency of 0 means it never answers.
  int         alu_lat = 0;
  logic [7:0] alu_ret = '0;
  logic       m_pend;
  int         m_cnt;
  logic [7:0] m_res;

  alu_req_arbiter #(.DATA_W(8), .OP_W(3), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_err(rsp_err),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result),
    .busy(busy), .grant_id(grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      m_pend <= 1'b0;
      m_cnt  <= 0;
      m_res  <= '0;
    end else if (alu_start && alu_lat != 0) begin
      m_pend <= 1'b1;
      m_cnt  <= alu_lat;
      m_res  <= alu_ret;
    end else if (m_pend) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_pend <= 1'b0;
    end
  end
  assign alu_done   = m_pend && (m_cnt == 1);
  assign alu_result = alu_done ? m_res : 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request from requester p while the arbiter is idle and
  // the other requester is quiet. It returns in the ISSUE cycle.
  task automatic accept(input int p, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    if (p == 0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    #1;
    check("acc_rdy0", req0_ready, p == 0);
    check("acc_rdy1", req1_ready, p == 1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("acc_start", alu_start, 1);
    check("acc_grant", grant_id, p);
    check("acc_op", alu_op, op);
    check("acc_a", alu_a, a);
    check("acc_b", alu_b, b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    tick(); tick();
    check("rst_busy", busy, 0);
    check("rst_rdy0", req0_ready, 0);
    check("rst_start", alu_start, 0);
    check("rst_grant", grant_id, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_result", rsp_result, 0);
    check("rst_err", rsp_err, 0);
    rst = 1'b0;

    // Single request from requester 0
    alu_lat = 2; alu_ret = 8'h46;
    accept(0, 3'b000, 8'h12, 8'h34);
    check("t1_rdy0_after", req0_ready, 0);
    tick();
    check("t1_start_once", alu_start, 0);
    tick();
    check("t1_rsp_early", rsp0_valid, 0);
    tick();
    check("t1_rsp0", rsp0_valid, 1);
    check("t1_rsp1", rsp1_valid, 0);
    check("t1_result", rsp_result, 8'h46);
    check("t1_err", rsp_err, 0);
    tick();
    check("t1_idle", busy, 0);

    // Both requesters held valid from reset: grants alternate 0,1,0,1
    rst = 1'b1;
    req0_valid = 1; req0_op = 3'd1; req0_a = 8'h01; req0_b = 8'h00;
    req1_valid = 1; req1_op = 3'd2; req1_a = 8'h02; req1_b = 8'h00;
    alu_lat = 1; alu_ret = 8'h10;
    tick();
    check("t2_rst_rdy0", req0_ready, 0);
    check("t2_rst_rdy1", req1_ready, 0);
    tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      int g;
      g = i % 2;
      check("t2_rdy0", req0_ready, g == 0);
      check("t2_rdy1", req1_ready, g == 1);
      tick();
      check("t2_grant", grant_id, g);
      check("t2_alu_a", alu_a, (g == 1) ? 8'h02 : 8'h01);
      check("t2_busy_rdy0", req0_ready, 0);
      check("t2_busy_rdy1", req1_ready, 0);
      tick();
      check("t2_wait_rdy", req0_ready | req1_ready, 0);
      tick();
      check("t2_rsp0", rsp0_valid, g == 0);
      check("t2_rsp1", rsp1_valid, g == 1);
      tick();
    end
    req0_valid = 0; req1_valid = 0;
    tick();

    // Timeout: the ALU never answers, then a normal transaction follows
    alu_lat = 0;
    accept(0, 3'd5, 8'hAA, 8'h55);
    repeat (16) tick();
    check("t3_rsp_s16", rsp0_valid, 0);
    tick();
    check("t3_rsp_s17", rsp0_valid, 1);
    check("t3_err", rsp_err, 1);
    check("t3_result", rsp_result, 0);
    tick();
    check("t3_err_clr", rsp_err, 0);
    check("t3_idle", busy, 0);
    alu_lat = 2; alu_ret = 8'h5A;
    accept(0, 3'd1, 8'h2D, 8'h2D);
    tick(); tick(); tick();
    check("t3_next_rsp", rsp0_valid, 1);
    check("t3_next_err", rsp_err, 0);
    check("t3_next_res", rsp_result, 8'h5A);
    tick();

    // Response backpressure on requester 0 while requester 1 waits
    rsp0_ready = 1'b0;
    alu_lat = 1; alu_ret = 8'h99;
    accept(0, 3'd3, 8'h11, 8'h22);
    tick(); tick();
    check("t4_rsp0", rsp0_valid, 1);
    req1_valid = 1; req1_op = 3'd4; req1_a = 8'h77; req1_b = 8'h01;
    alu_ret = 8'h78;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("t4_hold_valid", rsp0_valid, 1);
      check("t4_hold_result", rsp_result, 8'h99);
      check("t4_no_rdy1", req1_ready, 0);
      tick();
    end
    rsp0_ready = 1'b1;
    #1;
    check("t4_hs_rdy1", req1_ready, 0);
    tick();
    check("t4_rdy1", req1_ready, 1);
    check("t4_idle", busy, 0);
    tick();
    req1_valid = 0;
    check("t4_grant1", grant_id, 1);
    check("t4_alu_a", alu_a, 8'h77);
    tick(); tick();
    check("t4_rsp1", rsp1_valid, 1);
    check("t4_rsp0_low", rsp0_valid, 0);
    check("t4_result", rsp_result, 8'h78);
    tick();

    // Reset while in WAIT abandons the transaction
    alu_lat = 0;
    accept(0, 3'd6, 8'h01, 8'h02);
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_rsp0", rsp0_valid, 0);
    check("t5_rsp1", rsp1_valid, 0);
    check("t5_start", alu_start, 0);
    alu_lat = 2; alu_ret = 8'h3C;
    accept(1, 3'd2, 8'h20, 8'h1C);
    tick(); tick(); tick();
    check("t5_rsp1", rsp1_valid, 1);
    check("t5_rsp0_low", rsp0_valid, 0);
    check("t5_result", rsp_result, 8'h3C);
    check("t5_err", rsp_err, 0);
    tick();

    // Done arrives on the last counter cycle and wins over the timeout
    alu_lat = 16; alu_ret = 8'hA5;
    accept(0, 3'd7, 8'h0F, 8'hF0);
    repeat (16) tick();
    check("t6_rsp_s16", rsp0_valid, 0);
    tick();
    check("t6_rsp_s17", rsp0_valid, 1);
    check("t6_err", rsp_err, 0);
    check("t6_result", rsp_result, 8'hA5);
    tick();
    check("t6_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Shares the single ALU core between two requesters (for example a host-side command port and an internal sequencer) using round-robin arbitration. Captures one request, issues it to the ALU through a start/done handshake, waits for completion with a timeout guard, and returns the result to the winning requester. Sits between the requester ports and the ALU datapath inside the top-level wrapper.

Parameters:
DATA_W, 8, operand and result width
OP_W, 3, ALU opcode width
TIMEOUT, 16, maximum cycles in WAIT before an error response (legal range 2..255)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 request accepted this cycle
req0_op  in  OP_W  requester 0 opcode
req0_a  in  DATA_W  requester 0 operand A
req0_b  in  DATA_W  requester 0 operand B
req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
rsp0_valid  out  1  response for requester 0 valid
rsp0_ready  in  1  requester 0 accepts the response
rsp1_valid  out  1  response for requester 1 valid
rsp1_ready  in  1  requester 1 accepts the response
rsp_result  out  DATA_W  result, shared by both response ports
rsp_err  out  1  1 = ALU timed out; rsp_result is 0
alu_start  out  1  one-cycle issue pulse to the ALU
alu_op  out  OP_W  registered opcode to the ALU
alu_a  out  DATA_W  registered operand A
alu_b  out  DATA_W  registered operand B
alu_done  in  1  ALU completion pulse
alu_result  in  DATA_W  ALU result, valid while alu_done = 1
busy  out  1  FSM not in IDLE
grant_id  out  1  requester currently owning the ALU

Behaviour:
- Reset (synchronous, rst=1 at a rising clk edge): state=IDLE; all ready, valid, start and err outputs 0; alu_op, alu_a, alu_b, rsp_result = 0; grant_id=0; last_grant=1, so requester 0 wins first; timeout counter=0. A reset mid-operation abandons the transaction with no response. The ALU ignores the lost transaction.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If no req*_valid is asserted, stay in IDLE.
  - Otherwise pick a winner. If only one requester is valid, it wins. If both are valid, the winner is the requester that is not last_grant.
  - In the same cycle, assert reqN_ready combinationally for the winner only. At the clock edge, register op, a and b into alu_*, set grant_id, and go to ISSUE.
  - ready is asserted only in IDLE, and never for both requesters at once.
- ISSUE: alu_start=1 for exactly one cycle; clear the counter; go to WAIT. alu_* stay stable until the next grant.
- WAIT: alu_done is sampled only in this state. The ALU must not assert done in the ISSUE cycle; a done in ISSUE is ignored.
  - If alu_done=1: capture alu_result into rsp_result, rsp_err=0, go to RESP.
  - Else if counter == TIMEOUT-1: rsp_result=0, rsp_err=1, go to RESP.
  - Otherwise increment the counter.
  - If done arrives on the cycle the counter reaches TIMEOUT-1, done wins (no error).
- RESP:
  - rspN_valid=1 for N = grant_id only. Hold rsp_result and rsp_err stable until rspN_ready=1.
  - On the handshake cycle: last_grant=grant_id, clear rsp_err, return to IDLE.
  - A new request is accepted no earlier than the cycle after the handshake.
- Latency: a request accepted at cycle T gives alu_start at T+1. If alu_done arrives at T+1+k (k≥1), rspN_valid rises at T+2+k. Minimum accept-to-accept spacing is 4 cycles.
- Requests arriving while busy see ready=0 and must hold valid and operands.
- alu_done asserted in IDLE or RESP is ignored.

Test Plan:
- Single request: reset, then req0 op=3'b000 a=8'h12 b=8'h34; the ALU model returns 8'h46 two cycles after start → req0_ready pulses once; alu_start appears one cycle later; rsp0_valid with rsp_result=8'h46, rsp_err=0; rsp1_valid stays 0.
- Simultaneous requests: req0 and req1 held valid from reset with rsp*_ready=1 → grants go 0,1,0,1 over four transactions; each requester sees exactly one ready per transaction.
- Timeout: the ALU never asserts done, TIMEOUT=16 → rspN_valid rises 17 cycles after alu_start with rsp_err=1 and rsp_result=0; the next transaction completes normally with rsp_err=0.
- Response backpressure: rsp0_ready held 0 for 10 cycles → rsp0_valid and rsp_result stay stable; req1_valid=1 during this time sees no ready; req1 is granted the cycle after rsp0_ready=1.
- Reset mid-WAIT: assert rst for 1 cycle while in WAIT → next cycle busy=0, no rsp*_valid, alu_start=0; a new req1 is then accepted and completes correctly.
- Done/timeout race: alu_done asserted exactly on the counter==TIMEOUT-1 cycle with alu_result=8'hA5 → rsp_err=0, rsp_result=8'hA5.
